// File: rtl/seq_scan_ctrl.sv
// Word-to-serial scan controller for one 1011 sequence detector: shifts words MSB-first,
// attributes detector hits per word and keeps a saturating total. Optional irq: SEQ_SCAN_IRQ_EN.
module seq_scan_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             word_valid,
   input  logic [WIDTH-1:0] word_data,
   output logic             word_ready,
   input  logic             clear,
   input  logic [CNT_W-1:0] thresh,
   output logic             det_reset,
   output logic             det_seq_in,
   input  logic             det_detect,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] word_hits,
   output logic [CNT_W-1:0] total_hits,
   output logic             irq
);

   // state  | meaning
   // IDLE   | detector held in reset, ready for a word
   // SHIFT  | presenting word bits MSB-first, one per clock
   // DRAIN  | two cycles collecting the detector's pipelined hits
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam int TMR_W = $clog2(WIDTH);
   localparam logic [TMR_W-1:0] SHIFT_TC  = TMR_W'(WIDTH - 1);
   localparam logic [TMR_W-1:0] ATTRIB_TC = TMR_W'(WIDTH - 3);
   localparam logic [TMR_W-1:0] DRAIN_TC  = TMR_W'(1);
   localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
   logic [CNT_W-1:0] word_hits_q, word_hits_d;
   logic [CNT_W-1:0] total_q, total_d;
   logic             done_q, done_d;
   logic             irq_q, irq_d;
   logic             word_ready_q, word_ready_d;
   logic             busy_q, busy_d;
   logic             det_reset_q, det_reset_d;
   logic             attrib;
   logic             hit;

   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      tmr_d       = tmr_q;
      hit_cnt_d   = hit_cnt_q;
      word_hits_d = word_hits_q;
      total_d     = total_q;
      done_d      = 1'b0;
      attrib      = 1'b0;
      hit         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (word_valid) begin
               state_d   = ST_SHIFT;
               sr_d      = word_data;
               tmr_d     = SHIFT_TC;
               hit_cnt_d = '0;
            end
         end
         ST_SHIFT: begin
            sr_d   = {sr_q[WIDTH-2:0], 1'b0};
            // detector output lags the presented bit by two clocks
            attrib = (tmr_q <= ATTRIB_TC);
            if (tmr_q == '0) begin
               state_d = ST_DRAIN;
               tmr_d   = DRAIN_TC;
            end else begin
               tmr_d = tmr_q - TMR_ONE;
            end
         end
         ST_DRAIN: begin
            attrib = 1'b1;
            if (tmr_q == '0) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               tmr_d = tmr_q - TMR_ONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      hit = attrib & det_detect;
      if (hit) begin
         hit_cnt_d = hit_cnt_q + CNT_ONE;
      end
      if (done_d) begin
         word_hits_d = hit_cnt_d;
      end

      if (clear) begin
         total_d = '0;
      end else if (hit && (total_q != CNT_MAX)) begin
         total_d = total_q + CNT_ONE;
      end

      word_ready_d = (state_d == ST_IDLE);
      busy_d       = (state_d != ST_IDLE);
      det_reset_d  = (state_d == ST_IDLE);
   end

`ifdef SEQ_SCAN_IRQ_EN
   always_comb begin
      irq_d = irq_q;
      if (clear) begin
         irq_d = 1'b0;
      end else if ((thresh != '0) && (total_q >= thresh)) begin
         irq_d = 1'b1;
      end
   end
`else
   logic thresh_unused;
   assign thresh_unused = ^thresh;
   always_comb begin
      irq_d = 1'b0;
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         sr_q         <= '0;
         tmr_q        <= '0;
         hit_cnt_q    <= '0;
         word_hits_q  <= '0;
         total_q      <= '0;
         done_q       <= 1'b0;
         irq_q        <= 1'b0;
         word_ready_q <= 1'b1;
         busy_q       <= 1'b0;
         det_reset_q  <= 1'b1;
      end else begin
         state_q      <= state_d;
         sr_q         <= sr_d;
         tmr_q        <= tmr_d;
         hit_cnt_q    <= hit_cnt_d;
         word_hits_q  <= word_hits_d;
         total_q      <= total_d;
         done_q       <= done_d;
         irq_q        <= irq_d;
         word_ready_q <= word_ready_d;
         busy_q       <= busy_d;
         det_reset_q  <= det_reset_d;
      end
   end

   // shift register drains to zero, so its MSB is 0 outside SHIFT
   assign det_seq_in = sr_q[WIDTH-1];
   assign word_ready = word_ready_q;
   assign busy       = busy_q;
   assign det_reset  = det_reset_q;
   assign done       = done_q;
   assign word_hits  = word_hits_q;
   assign total_hits = total_q;
   assign irq        = irq_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Bench for seq_scan_ctrl: behavioural 1011 detectors, a table of directed words, corner
// sequences (back-to-back, clear vs hit, mid-word reset, saturation) and random words.
module tb_seq_scan_ctrl;
   localparam int W   = 8;
   localparam int CW  = 8;
   localparam int SW  = 7;
   localparam int SCW = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n;
   logic          word_valid, word_ready, clear;
   logic [W-1:0]  word_data;
   logic [CW-1:0] thresh, word_hits, total_hits;
   logic          det_reset, det_seq_in, det_detect, busy, done, irq;

   logic           s_valid, s_ready, s_clear;
   logic [SW-1:0]  s_data;
   logic [SCW-1:0] s_thresh, s_word_hits, s_total;
   logic           s_det_reset, s_seq, s_det, s_busy, s_done, s_irq;

   int n_total = 0;
   int n_bad   = 0;

   seq_scan_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk(clk), .reset_n(reset_n), .word_valid(word_valid), .word_data(word_data),
      .word_ready(word_ready), .clear(clear), .thresh(thresh), .det_reset(det_reset),
      .det_seq_in(det_seq_in), .det_detect(det_detect), .busy(busy), .done(done),
      .word_hits(word_hits), .total_hits(total_hits), .irq(irq));

   seq_scan_ctrl #(.WIDTH(SW), .CNT_W(SCW)) dut_sat (
      .clk(clk), .reset_n(reset_n), .word_valid(s_valid), .word_data(s_data),
      .word_ready(s_ready), .clear(s_clear), .thresh(s_thresh), .det_reset(s_det_reset),
      .det_seq_in(s_seq), .det_detect(s_det), .busy(s_busy), .done(s_done),
      .word_hits(s_word_hits), .total_hits(s_total), .irq(s_irq));

   // Overlapping Moore 1011 detectors with registered output (two-clock latency)
   logic [2:0] m_hist, s_hist;
   logic       m_st, s_st;
   always @(posedge clk or posedge det_reset) begin
      if (det_reset) begin
         m_hist <= '0; m_st <= 1'b0; det_detect <= 1'b0;
      end else begin
         m_hist     <= {m_hist[1:0], det_seq_in};
         m_st       <= ({m_hist, det_seq_in} == 4'b1011);
         det_detect <= m_st;
      end
   end
   always @(posedge clk or posedge s_det_reset) begin
      if (s_det_reset) begin
         s_hist <= '0; s_st <= 1'b0; s_det <= 1'b0;
      end else begin
         s_hist <= {s_hist[1:0], s_seq};
         s_st   <= ({s_hist, s_seq} == 4'b1011);
         s_det  <= s_st;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int count_1011(input logic [31:0] w, input int n);
      int c = 0;
      for (int i = 0; i + 3 < n; i++)
         if (w[n-1-i -: 4] == 4'b1011) c++;
      return c;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      clear = 1'b1; s_clear = 1'b1;
      tick();
      clear = 1'b0; s_clear = 1'b0;
   endtask

   // Offer d in the current cycle (A); clear is pulsed in cycle A+clr_at if clr_at>0.
   // Junk valid/data is offered while busy and must be ignored.
   task automatic send_main(input logic [W-1:0] d, input int clr_at, output int lat);
      word_valid = 1'b1; word_data = d;
      tick();
      word_valid = 1'b0; word_data = W'($urandom);
      lat = 1;
      chk("shift_det_reset", det_reset, 0);
      chk("shift_first_bit", det_seq_in, d[W-1]);
      chk("shift_busy", busy, 1);
      chk("shift_not_ready", word_ready, 0);
      while (!done && lat < 30) begin
         clear = (lat == clr_at);
         if (lat < 10) begin
            word_valid = 1'($urandom_range(0, 1));
            word_data  = W'($urandom);
         end else begin
            word_valid = 1'b0;
         end
         tick();
         lat++;
      end
      clear = 1'b0; word_valid = 1'b0;
      chk("done_latency", lat, W + 3);
      chk("done_det_reset", det_reset, 1);
   endtask

   task automatic send_sat(input logic [SW-1:0] d, output int lat);
      s_valid = 1'b1; s_data = d;
      tick();
      s_valid = 1'b0;
      lat = 1;
      while (!s_done && lat < 30) begin
         tick();
         lat++;
      end
      chk("sat_done_latency", lat, SW + 3);
   endtask

   typedef struct {
      logic         clr;
      logic [W-1:0] word;
      int           hits;
      int           tot;
   } vec_t;

   vec_t tbl[7];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lat, lat2, m_tot, exp, pulses, p;
      logic [W-1:0] d;

      tbl[0] = '{1'b1, 8'hB0, 1, 1};
      tbl[1] = '{1'b1, 8'hB6, 2, 2};
      tbl[2] = '{1'b0, 8'hFF, 0, 2};
      tbl[3] = '{1'b0, 8'h00, 0, 2};
      tbl[4] = '{1'b1, 8'hBB, 2, 2};
      tbl[5] = '{1'b0, 8'h5B, 2, 4};
      tbl[6] = '{1'b0, 8'hDB, 2, 6};

      reset_n = 1'b0; word_valid = 1'b0; word_data = '0; clear = 1'b0; thresh = '0;
      s_valid = 1'b0; s_data = '0; s_clear = 1'b0; s_thresh = '0;
      tick(); tick();
      chk("rst_ready", word_ready, 1);
      chk("rst_det_reset", det_reset, 1);
      chk("rst_seq_in", det_seq_in, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_word_hits", word_hits, 0);
      chk("rst_total", total_hits, 0);
      chk("rst_irq", irq, 0);
      chk("rst_sat_det_reset", s_det_reset, 1);
      reset_n = 1'b1;
      tick();
      chk("idle_ready", word_ready, 1);
      chk("idle_det_reset", det_reset, 1);

      for (int i = 0; i < 7; i++) begin
         if (tbl[i].clr) do_clear();
         send_main(tbl[i].word, -1, lat);
         chk($sformatf("tbl%0d_hits", i), word_hits, tbl[i].hits);
         chk($sformatf("tbl%0d_total", i), total_hits, tbl[i].tot);
         chk($sformatf("tbl%0d_ready", i), word_ready, 1);
      end
      tick();
      chk("done_is_pulse", done, 0);
      chk("word_hits_held", word_hits, 2);

      // back-to-back with valid held: second accept lands in the first done cycle
      do_clear();
      word_valid = 1'b1; word_data = 8'h05;
      tick();
      word_data = 8'hC0;
      lat = 1;
      while (!done && lat < 30) begin tick(); lat++; end
      chk("b2b_first_latency", lat, W + 3);
      chk("b2b_first_hits", word_hits, 0);
      chk("b2b_ready_in_done", word_ready, 1);
      tick();
      word_valid = 1'b0;
      chk("b2b_second_accepted", busy, 1);
      lat = 1;
      while (!done && lat < 30) begin tick(); lat++; end
      chk("b2b_second_latency", lat, W + 3);
      chk("b2b_second_hits", word_hits, 0);
      chk("b2b_total", total_hits, 0);

      // clear coinciding with the only hit (1011 ends at bit 3, reported in A+6)
      send_main(8'hB6, -1, lat);
      do_clear();
      send_main(8'hB0, 6, lat);
      chk("clr_hit_word_hits", word_hits, 1);
      chk("clr_hit_total", total_hits, 0);
      chk("clr_hit_irq", irq, 0);
      send_main(8'hB0, -1, lat);
      chk("after_clr_total", total_hits, 1);

      // reset in SHIFT cycle 4
      send_main(8'hB6, -1, lat);
      word_valid = 1'b1; word_data = 8'hB0;
      tick();
      word_valid = 1'b0;
      repeat (4) tick();
      reset_n = 1'b0;
      #1;
      chk("midrst_det_reset", det_reset, 1);
      chk("midrst_busy", busy, 0);
      chk("midrst_ready", word_ready, 1);
      chk("midrst_word_hits", word_hits, 0);
      chk("midrst_total", total_hits, 0);
      chk("midrst_seq_in", det_seq_in, 0);
      tick();
      reset_n = 1'b1;
      pulses = 0;
      for (int c = 0; c < W + 6; c++) begin
         if (done) pulses++;
         tick();
      end
      chk("midrst_no_done", pulses, 0);
      send_main(8'hB0, -1, lat);
      chk("midrst_fresh_hits", word_hits, 1);
      chk("midrst_fresh_total", total_hits, 1);

`ifdef SEQ_SCAN_IRQ_EN
      thresh = 8'd3;
      do_clear();
      send_main(8'hB0, -1, lat);
      tick();
      chk("irq_after_1", irq, 0);
      send_main(8'hB0, -1, lat);
      tick();
      chk("irq_after_2", irq, 0);
      send_main(8'hB0, -1, lat);
      chk("irq_after_3", irq, 1);
      tick();
      chk("irq_sticky", irq, 1);
      do_clear();
      chk("irq_cleared", irq, 0);
      chk("irq_clr_total", total_hits, 0);
      thresh = '0;
`endif

      // saturating total with a 3-bit counter
      do_clear();
      for (int k = 0; k < 5; k++) begin
         send_sat(7'b1011011, lat);
         chk($sformatf("sat%0d_hits", k), s_word_hits, 2);
         chk($sformatf("sat%0d_total", k), s_total, (2 * (k + 1) > 7) ? 7 : 2 * (k + 1));
      end
      do_clear();
      chk("sat_clear", s_total, 0);
      chk("sat_irq", s_irq, 0);

      // random words against the string-matching model
      do_clear();
      m_tot = 0;
      for (int r = 0; r < 40; r++) begin
         repeat ($urandom_range(0, 2)) tick();
         if ($urandom_range(0, 5) == 0) begin
            do_clear();
            m_tot = 0;
         end
         d = W'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            p = $urandom_range(3, W - 1);
            d[p -: 4] = 4'b1011;
         end
         exp = count_1011(32'(d), W);
         send_main(d, -1, lat2);
         m_tot = (m_tot + exp > 255) ? 255 : m_tot + exp;
         chk($sformatf("rnd%0d_hits(%02h)", r, d), word_hits, exp);
         chk($sformatf("rnd%0d_total", r), total_hits, m_tot);
         chk($sformatf("rnd%0d_irq", r), irq, 0);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
